tlp_tx_sched: RTL and testbench

- Packet-granular scheduler that shares one downstream TLP transmit stream between two TLP source FIFOs.
  - Source 0: the Ethernet-decapsulated TLP FIFO.
  - Source 1: the locally generated TLP FIFO, e.g. NetTLP command responses.
- Each source signals a fully written packet with a one-cycle `pkt_done` pulse. The scheduler counts complete packets per source and grants whole packets round-robin.
- It drains the granted first-word-fall-through (FWFT) FIFO onto an AXI-Stream master that feeds the PCIe TX clock-crossing FIFO.
- A beat watchdog truncates runaway packets.

---
 rtl/tlp_tx_sched.sv | 156 +++++++++++++++
 tb/tb_tlp_tx_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_tx_sched.sv
// tlp_tx_sched: packet-granular scheduler sharing one AXI-Stream TLP TX path
// between two FWFT source FIFOs.
//   Source 0: Ethernet-decapsulated TLPs. Source 1: locally generated TLPs.
// Sources announce each fully written packet with a pkt_done pulse. Whole packets
// are granted round-robin, and the granted FIFO is drained onto the m_* master.
// A beat watchdog forces tlast on beat MAX_BEATS-1 and discards the rest of the
// runaway packet in DRAIN.
// Ports:
//   eth_clk, eth_rst         clock, synchronous active-high reset
//   sN_pkt_done              one-cycle pulse: one complete packet in FIFO N
//   sN_rd_en                 FWFT read strobe to FIFO N
//   sN_empty/tdata/tkeep/tlast  FIFO N head
//   m_tvalid/tready/tdata/tkeep/tlast  AXI-Stream master
//   grant                    source currently or last served
//   busy                     high in SEND or DRAIN
//   err_ovf[1:0]             sticky per-source packet-counter saturation
//   err_trunc                sticky watchdog truncation
// Optional feature: define TLP_TX_SCHED_STRICT_PRIO_EN for fixed priority
// (source 0 wins whenever it is eligible) instead of round-robin.
module tlp_tx_sched #(
  parameter int CNT_W     = 6,
  parameter int MAX_BEATS = 64
) (
  input  logic        eth_clk,
  input  logic        eth_rst,
  input  logic        s0_pkt_done,
  output logic        s0_rd_en,
  input  logic        s0_empty,
  input  logic [63:0] s0_tdata,
  input  logic [7:0]  s0_tkeep,
  input  logic        s0_tlast,
  input  logic        s1_pkt_done,
  output logic        s1_rd_en,
  input  logic        s1_empty,
  input  logic [63:0] s1_tdata,
  input  logic [7:0]  s1_tkeep,
  input  logic        s1_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  output logic        grant,
  output logic        busy,
  output logic [1:0]  err_ovf,
  output logic        err_trunc
);
  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

  localparam logic [6:0]       LAST_BEAT = 7'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t                 state_q;
  logic                   grant_q, busy_q, trunc_q;
  logic [6:0]             beat_q;
  logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]             ovf_q, ovf_d;

  // Head of the granted FIFO
  logic        sel_empty, sel_tlast;
  logic [63:0] sel_tdata;
  logic [7:0]  sel_tkeep;
  assign sel_empty = grant_q ? s1_empty : s0_empty;
  assign sel_tlast = grant_q ? s1_tlast : s0_tlast;
  assign sel_tdata = grant_q ? s1_tdata : s0_tdata;
  assign sel_tkeep = grant_q ? s1_tkeep : s0_tkeep;

  logic in_send, in_drain, beat_lim, acc, sel_rd, pkt_end;
  assign in_send  = (state_q == SEND);
  assign in_drain = (state_q == DRAIN);
  assign beat_lim = (beat_q == LAST_BEAT);

  // Datapath is a straight pass-through of the FWFT head, so it holds still
  // under backpressure as long as the FIFO is not read.
  assign m_tvalid = in_send & ~sel_empty;
  assign m_tdata  = in_send ? sel_tdata : '0;
  assign m_tkeep  = in_send ? sel_tkeep : '0;
  assign m_tlast  = in_send & (sel_tlast | beat_lim);
  assign acc      = m_tvalid & m_tready;
  // DRAIN reads blindly to throw away the tail of a truncated packet
  assign sel_rd   = acc | (in_drain & ~sel_empty);
  assign s0_rd_en = sel_rd & ~grant_q;
  assign s1_rd_en = sel_rd &  grant_q;
  // Packet completion: natural or forced tlast accepted
  assign pkt_end  = acc & (sel_tlast | beat_lim);

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign err_ovf   = ovf_q;
  assign err_trunc = trunc_q;

  logic [1:0] inc, dec, elig;
  logic       pick;
  assign inc = {s1_pkt_done, s0_pkt_done};
  assign dec = {pkt_end & grant_q, pkt_end & ~grant_q};
  assign elig = {cnt_q[1] != '0, cnt_q[0] != '0};

`ifdef TLP_TX_SCHED_STRICT_PRIO_EN
  assign pick = ~elig[0];
`else
  // Tie goes to the source not served last
  assign pick = (&elig) ? ~grant_q : ~elig[0];
`endif

  // Complete-packet counters: inc and dec together cancel out
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < 2; i++) begin
      if (inc[i] && !dec[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec[i] && !inc[i] && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge eth_clk) begin
    if (eth_rst) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      busy_q  <= 1'b0;
      beat_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      case (state_q)
        IDLE: if (|elig) begin
          grant_q <= pick;
          beat_q  <= '0;
          busy_q  <= 1'b1;
          state_q <= SEND;
        end
        SEND: if (acc) begin
          beat_q <= beat_q + 7'd1;
          if (sel_tlast) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (beat_lim) begin
            trunc_q <= 1'b1;
            state_q <= DRAIN;
          end
        end
        DRAIN: if (!sel_empty && sel_tlast) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlp_tx_sched.sv
// Bench for tlp_tx_sched: FWFT FIFO models feed the DUT, a per-source scoreboard
// of expected output beats is filled when packets are written, and beats are
// popped and compared as the DUT hands them downstream.
module tb_tlp_tx_sched;
  localparam int MAXB = 64;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    logic rdy;
    logic d0;
    logic ev;
    logic el;
    logic eb;
    logic eg;
    int   ec;
  } vec_t;

  logic        eth_clk = 1'b0, eth_rst = 1'b1;
  logic        s0_pkt_done = 1'b0, s0_rd_en, s0_empty = 1'b1, s0_tlast = 1'b0;
  logic [63:0] s0_tdata = '0;
  logic [7:0]  s0_tkeep = '0;
  logic        s1_pkt_done = 1'b0, s1_rd_en, s1_empty = 1'b1, s1_tlast = 1'b0;
  logic [63:0] s1_tdata = '0;
  logic [7:0]  s1_tkeep = '0;
  logic        m_tvalid, m_tready = 1'b1, m_tlast, grant, busy, err_trunc;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [1:0]  err_ovf;

  tlp_tx_sched #(.CNT_W(6), .MAX_BEATS(MAXB)) dut (
    .eth_clk(eth_clk), .eth_rst(eth_rst),
    .s0_pkt_done(s0_pkt_done), .s0_rd_en(s0_rd_en), .s0_empty(s0_empty),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
    .s1_pkt_done(s1_pkt_done), .s1_rd_en(s1_rd_en), .s1_empty(s1_empty),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .grant(grant), .busy(busy),
    .err_ovf(err_ovf), .err_trunc(err_trunc)
  );

  always #5 eth_clk = ~eth_clk;

  int n_vec = 0, n_err = 0;
  beat_t q0[$], q1[$], e0[$], e1[$];

  // Next-cycle stimulus; pkt_done requests are one-shot
  logic rdy_nx = 1'b1, d0_nx = 1'b0, d1_nx = 1'b0, rst_nx = 1'b1;
  // Per-cycle observations
  logic rst_seen = 1'b0, pop0 = 1'b0, pop1 = 1'b0;
  logic acc = 1'b0, stalled = 1'b0;
  logic [63:0] prev_d = '0;
  int cyc = 0, drain_cnt = 0, acc_total = 0;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic push_pkt(input int src, input int id, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = {8'(src), 8'(id), 16'(i), 32'hC0DE0000};
      b.k = (i == n - 1) ? 8'h0F : 8'hFF;
      b.l = (i == n - 1);
      if (src == 0) q0.push_back(b); else q1.push_back(b);
      // Watchdog model: only the first MAXB beats leave, the last one marked tlast
      if (i < MAXB) begin
        b.l = b.l | (i == MAXB - 1);
        if (src == 0) e0.push_back(b); else e1.push_back(b);
      end
    end
  endtask

  // One clock: retire reads from the edge just past, drive the next inputs,
  // then sample the settled outputs well before the next rising edge.
  task automatic tick();
    beat_t t, e;
    @(negedge eth_clk);
    if (rst_seen) begin
      q0.delete(); q1.delete(); e0.delete(); e1.delete();
    end else begin
      if (pop0) t = q0.pop_front();
      if (pop1) t = q1.pop_front();
    end
    s0_empty = (q0.size() == 0);
    s1_empty = (q1.size() == 0);
    if (q0.size() != 0) {s0_tdata, s0_tkeep, s0_tlast} = q0[0];
    else {s0_tdata, s0_tkeep, s0_tlast} = '0;
    if (q1.size() != 0) {s1_tdata, s1_tkeep, s1_tlast} = q1[0];
    else {s1_tdata, s1_tkeep, s1_tlast} = '0;
    eth_rst = rst_nx;
    m_tready = rdy_nx;
    s0_pkt_done = d0_nx;
    s1_pkt_done = d1_nx;
    d0_nx = 1'b0;
    d1_nx = 1'b0;
    #1;
    cyc++;
    rst_seen = eth_rst;
    pop0 = s0_rd_en;
    pop1 = s1_rd_en;
    acc = m_tvalid & m_tready & ~eth_rst;
    if (!eth_rst) begin
      if (acc) begin
        acc_total++;
        if ((grant ? e1.size() : e0.size()) == 0) begin
          chk("unexpected_beat", {m_tdata, m_tkeep, m_tlast}, '0);
        end else begin
          e = grant ? e1.pop_front() : e0.pop_front();
          chk("beat", {m_tdata, m_tkeep, m_tlast}, e);
        end
      end
      if (m_tvalid)
        chk("rd_en_sel_oth", {(grant ? s1_rd_en : s0_rd_en), (grant ? s0_rd_en : s1_rd_en)},
            {m_tready, 1'b0});
      if (stalled) chk("stall_hold", {m_tvalid, m_tdata}, {1'b1, prev_d});
      if (!m_tvalid && (s0_rd_en || s1_rd_en)) drain_cnt++;
    end
    stalled = m_tvalid & ~m_tready & ~eth_rst;
    prev_d = m_tdata;
  endtask

  task automatic do_reset();
    rst_nx = 1'b1;
    rdy_nx = 1'b1;
    tick();
    tick();
    rst_nx = 1'b0;
    tick();
  endtask

  // The granted counter must never be decremented from zero
  always @(negedge eth_clk) begin
    #2;
    for (int i = 0; i < 2; i++)
      if (!eth_rst && dut.dec[i]) chk("dec_at_zero", {127'(0), dut.cnt_q[i] != '0}, 128'd1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[17];
    int   order[$];
    int   exp_order[4];
    int   last_tl, sop;
    int   pat[8];

    // ---- 1: reset values and a single 3-beat packet, cycle by cycle ----
    for (int c = 0; c < 17; c++) begin
      tbl[c].rdy = 1'b1;
      tbl[c].d0  = (c == 10);
      tbl[c].ev  = (c >= 12 && c <= 14);
      tbl[c].el  = (c == 14);
      tbl[c].eb  = (c >= 12 && c <= 14);
      tbl[c].eg  = (c < 12);
      tbl[c].ec  = (c >= 11 && c <= 14) ? 1 : 0;
    end
    do_reset();
    chk("rst_rd_en", {s0_rd_en, s1_rd_en}, 2'b00);
    chk("rst_err", {err_ovf, err_trunc}, 3'b000);
    chk("rst_cnt1", dut.cnt_q[1], 0);
    push_pkt(0, 1, 3);
    for (int c = 0; c < 17; c++) begin
      rdy_nx = tbl[c].rdy;
      d0_nx  = tbl[c].d0;
      tick();
      chk($sformatf("t1_valid_c%0d", c), m_tvalid, tbl[c].ev);
      chk($sformatf("t1_tlast_c%0d", c), m_tlast, tbl[c].el);
      chk($sformatf("t1_busy_c%0d", c), busy, tbl[c].eb);
      chk($sformatf("t1_grant_c%0d", c), grant, tbl[c].eg);
      chk($sformatf("t1_cnt0_c%0d", c), dut.cnt_q[0], tbl[c].ec);
    end
    chk("t1_sb_empty", e0.size(), 0);

    // ---- 2: two packets per source, service order and idle gap ----
`ifdef TLP_TX_SCHED_STRICT_PRIO_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    do_reset();
    push_pkt(0, 2, 2); push_pkt(0, 3, 2);
    push_pkt(1, 4, 2); push_pkt(1, 5, 2);
    d0_nx = 1'b1; d1_nx = 1'b1; tick();
    d0_nx = 1'b1; d1_nx = 1'b1; tick();
    last_tl = -1;
    sop = 1;
    for (int n = 0; n < 60 && order.size() < 4; n++) begin
      tick();
      if (acc) begin
        if (sop && last_tl >= 0) chk("t2_gap", cyc - last_tl, 2);
        sop = m_tlast;
        if (m_tlast) begin
          order.push_back(int'(grant));
          last_tl = cyc;
        end
      end
    end
    chk("t2_npkts", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk($sformatf("t2_order%0d", i), order[i], exp_order[i]);

    // ---- 3: backpressure 1,0,0,1 inside a 4-beat packet ----
    do_reset();
    push_pkt(0, 6, 4);
    pat = '{1, 0, 0, 1, 1, 1, 1, 1};
    acc_total = 0;
    d0_nx = 1'b1; tick();
    rdy_nx = 1'b0; tick();
    for (int k = 0; k < 8; k++) begin
      rdy_nx = pat[k][0];
      tick();
    end
    rdy_nx = 1'b1;
    tick();
    chk("t3_beats", acc_total, 4);
    chk("t3_sb_empty", e0.size(), 0);
    chk("t3_fifo_empty", q0.size(), 0);
    chk("t3_cnt0", dut.cnt_q[0], 0);

    // ---- 4: 70-beat runaway packet, then a clean 2-beat packet ----
    do_reset();
    push_pkt(0, 7, 70);
    push_pkt(0, 8, 2);
    d0_nx = 1'b1; tick();
    d0_nx = 1'b1; tick();
    chk("t4_trunc_pre", err_trunc, 1'b0);
    drain_cnt = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (e0.size() == 0 && !busy) break;
    end
    chk("t4_trunc", err_trunc, 1'b1);
    chk("t4_drained", drain_cnt, 6);
    chk("t4_sb_empty", e0.size(), 0);
    chk("t4_fifo_empty", q0.size(), 0);
    chk("t4_cnt0", dut.cnt_q[0], 0);

    // ---- 5: simultaneous pkt_done and completion, then saturation ----
    do_reset();
    for (int i = 0; i < 3; i++) begin d0_nx = 1'b1; tick(); end
    tick();
    chk("t5_cnt3", dut.cnt_q[0], 3);
    push_pkt(0, 9, 1);
    d0_nx = 1'b1;
    tick();
    chk("t5_acc_same", acc, 1'b1);
    tick();
    chk("t5_cnt_hold", dut.cnt_q[0], 3);
    chk("t5_sb_empty", e0.size(), 0);
    for (int i = 0; i < 60; i++) begin d0_nx = 1'b1; tick(); end
    tick();
    chk("t5_cnt63", dut.cnt_q[0], 63);
    chk("t5_ovf_pre", err_ovf, 2'b00);
    d0_nx = 1'b1; tick();
    tick();
    chk("t5_cnt_sat", dut.cnt_q[0], 63);
    chk("t5_ovf", err_ovf, 2'b01);

    // ---- 6: reset in the middle of a packet ----
    push_pkt(0, 10, 4);
    acc_total = 0;
    tick();
    tick();
    chk("t6_mid_beats", acc_total, 2);
    chk("t6_busy_pre", busy, 1'b1);
    rst_nx = 1'b1; tick();
    rst_nx = 1'b0; tick();
    chk("t6_state", dut.state_q, 0);
    chk("t6_valid", m_tvalid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_cnts", {dut.cnt_q[1], dut.cnt_q[0]}, 0);
    chk("t6_errs", {err_ovf, err_trunc}, 3'b000);
    chk("t6_grant", grant, 1'b1);
    tick();
    chk("t6_sb_clear", e0.size() + e1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
